// File: rtl/mmu_sequencer.sv
// Sequencer for a 4x4 systolic matrix unit: buffers one job of weight columns and
// data rows, plays them into the array, captures the bottom-row results and streams them out.
module mmu_sequencer #(
  parameter int LOAD_SETTLE  = 2,
  parameter int DRAIN_CYCLES = 8,
  parameter int OUT_DELAY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        tpu_control,
  output logic [31:0] tpu_wt_arr,
  output logic [31:0] tpu_data_arr,
  input  logic [23:0] pe30_in,
  input  logic [23:0] pe31_in,
  input  logic [23:0] pe32_in,
  input  logic [23:0] pe33_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [95:0] res_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5,
    S_OUTPUT = 3'd6
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(LOAD_SETTLE - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYCLES + 3);
  localparam logic [15:0] CAP_FIRST   = 16'(OUT_DELAY);
  localparam logic [15:0] CAP_LAST    = 16'(OUT_DELAY + 3);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [1:0]  kidx_r;
  logic [31:0] buf_r  [0:7];
  logic [95:0] slot_r [0:3];

  logic        in_ready_r;
  logic        ctrl_r;
  logic [31:0] wt_r;
  logic [31:0] data_r;
  logic        res_valid_r;
  logic [95:0] res_data_r;
  logic        busy_r;
  logic        done_r;

  logic [95:0] pe_word_s;
  logic        cap_hit_s;
  logic [1:0]  cap_idx_s;
  logic        beat_acc_s;

  assign in_ready     = in_ready_r;
  assign tpu_control  = ctrl_r;
  assign tpu_wt_arr   = wt_r;
  assign tpu_data_arr = data_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // Result capture window: the phase counter t is cnt_r during STREAM and DRAIN.
  always_comb begin
    pe_word_s  = {pe33_in, pe32_in, pe31_in, pe30_in};
    beat_acc_s = (state_r == S_FILL) && in_valid && in_ready_r;
    cap_idx_s  = 2'(cnt_r - CAP_FIRST);
    if ((state_r == S_STREAM || state_r == S_DRAIN) &&
        (cnt_r >= CAP_FIRST) && (cnt_r <= CAP_LAST)) begin
      cap_hit_s = 1'b1;
    end else begin
      cap_hit_s = 1'b0;
    end
  end

  // Input beat buffer: slots 0-3 weight columns, slots 4-7 data rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        buf_r[i] <= 32'd0;
      end
    end else if (beat_acc_s) begin
      buf_r[cnt_r[2:0]] <= in_data;
    end
  end

  // Result slots sampled from the bottom PE row at t = OUT_DELAY+k.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        slot_r[i] <= 96'd0;
      end
    end else if (cap_hit_s) begin
      slot_r[cap_idx_s] <= pe_word_s;
    end
  end

  // Job sequencing FSM; every output is loaded on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      kidx_r      <= 2'd0;
      in_ready_r  <= 1'b0;
      ctrl_r      <= 1'b0;
      wt_r        <= 32'd0;
      data_r      <= 32'd0;
      res_valid_r <= 1'b0;
      res_data_r  <= 96'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_FILL;
            cnt_r      <= 16'd0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        S_FILL: begin
          if (beat_acc_s) begin
            if (cnt_r[2:0] == 3'd7) begin
              state_r    <= S_LOAD;
              cnt_r      <= 16'd0;
              in_ready_r <= 1'b0;
              ctrl_r     <= 1'b1;
              wt_r       <= buf_r[0];
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        S_LOAD: begin
          if (cnt_r == 16'd3) begin
            wt_r  <= 32'd0;
            cnt_r <= 16'd0;
            if (LOAD_SETTLE == 0) begin
              state_r <= S_STREAM;
              ctrl_r  <= 1'b0;
              data_r  <= buf_r[4];
            end else begin
              state_r <= S_SETTLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
            wt_r  <= buf_r[{1'b0, cnt_r[1:0] + 2'd1}];
          end
        end
        S_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r <= S_STREAM;
            cnt_r   <= 16'd0;
            ctrl_r  <= 1'b0;
            data_r  <= buf_r[4];
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_STREAM, S_DRAIN: begin
          if (state_r == S_STREAM && cnt_r < 16'd3) begin
            data_r <= buf_r[{1'b1, cnt_r[1:0] + 2'd1}];
          end else begin
            data_r <= 32'd0;
          end
          if (cnt_r == DRAIN_LAST) begin
            state_r     <= S_OUTPUT;
            cnt_r       <= 16'd0;
            kidx_r      <= 2'd0;
            res_valid_r <= 1'b1;
            res_data_r  <= slot_r[0];
          end else begin
            cnt_r <= cnt_r + 16'd1;
            if (cnt_r == 16'd3) begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            if (kidx_r == 2'd3) begin
              state_r     <= S_IDLE;
              kidx_r      <= 2'd0;
              res_valid_r <= 1'b0;
              res_data_r  <= 96'd0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              kidx_r     <= kidx_r + 2'd1;
              res_data_r <= slot_r[kidx_r + 2'd1];
            end
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= 16'd0;
          kidx_r      <= 2'd0;
          in_ready_r  <= 1'b0;
          ctrl_r      <= 1'b0;
          wt_r        <= 32'd0;
          data_r      <= 32'd0;
          res_valid_r <= 1'b0;
          res_data_r  <= 96'd0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Self-checking bench for mmu_sequencer: a job table plus randomized jobs, each
// checked cycle by cycle against a phase timeline derived from the job's beats.
module tb_mmu_sequencer;

  localparam int LS = 2;
  localparam int DC = 8;
  localparam int OD = 4;
  localparam int RUN_LEN = 4 + LS + 4 + DC;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, res_ready;
  logic [31:0] in_data;
  logic        in_ready, tpu_control, res_valid, busy, done;
  logic [31:0] tpu_wt_arr, tpu_data_arr;
  logic [95:0] pe_bus, res_data;

  int tests = 0;
  int fails = 0;
  logic [95:0] pe_t [0:RUN_LEN-1];

  typedef struct {
    logic [7:0][31:0] beats;
    int gap_at;
    int gap_len;
    int bp_k;
    int bp_len;
    bit start_extra;
    int abort_t;
    int exp_ctrl_cycles;
    int exp_latency;
  } job_t;

  job_t jobs [5];

  always #5 clk = ~clk;

  mmu_sequencer #(.LOAD_SETTLE(LS), .DRAIN_CYCLES(DC), .OUT_DELAY(OD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tpu_control(tpu_control), .tpu_wt_arr(tpu_wt_arr), .tpu_data_arr(tpu_data_arr),
    .pe30_in(pe_bus[23:0]), .pe31_in(pe_bus[47:24]),
    .pe32_in(pe_bus[71:48]), .pe33_in(pe_bus[95:72]),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_ready"}, 96'(in_ready), 96'd0);
    chk({tag, "_control"},  96'(tpu_control), 96'd0);
    chk({tag, "_wt"},       96'(tpu_wt_arr), 96'd0);
    chk({tag, "_data"},     96'(tpu_data_arr), 96'd0);
    chk({tag, "_res_valid"}, 96'(res_valid), 96'd0);
    chk({tag, "_res_data"}, res_data, 96'd0);
    chk({tag, "_busy"},     96'(busy), 96'd0);
    chk({tag, "_done"},     96'(done), 96'd0);
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic job_t mk(input logic [7:0][31:0] b, input int ga, input int gl,
                              input int bk, input int bl, input bit se, input int ab);
    job_t j;
    j.beats = b; j.gap_at = ga; j.gap_len = gl; j.bp_k = bk; j.bp_len = bl;
    j.start_extra = se; j.abort_t = ab;
    j.exp_ctrl_cycles = 4 + LS;
    j.exp_latency = 4 + LS + 4 + DC;
    return j;
  endfunction

  task automatic run_job(input job_t j, input string tag);
    int ctrl_cnt, k, guard, bp_left, t;
    logic [31:0] exp_wt, exp_data;
    // IDLE: start, optionally with a beat that must not be taken
    start = 1'b1;
    in_valid = j.start_extra;
    in_data = 32'hdead_beef;
    chk({tag, "_idle_in_ready"}, 96'(in_ready), 96'd0);
    chk({tag, "_idle_busy"}, 96'(busy), 96'd0);
    tick();
    start = j.start_extra;
    for (int i = 0; i < 8; i++) begin
      if (i == j.gap_at) begin
        for (int g = 0; g < j.gap_len; g++) begin
          in_valid = 1'b0;
          chk({tag, "_gap_in_ready"}, 96'(in_ready), 96'd1);
          chk({tag, "_gap_control"}, 96'(tpu_control), 96'd0);
          tick();
          start = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_data = j.beats[i];
      chk({tag, "_fill_in_ready"}, 96'(in_ready), 96'd1);
      chk({tag, "_fill_busy"}, 96'(busy), 96'd1);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    ctrl_cnt = 0;
    for (int c = 0; c < j.exp_latency; c++) begin
      t = c - 4 - LS;
      exp_wt = (c < 4) ? j.beats[c] : 32'd0;
      exp_data = (t >= 0 && t < 4) ? j.beats[4 + t] : 32'd0;
      pe_bus = rand96();
      if (t >= 0) pe_t[t] = pe_bus;
      if (tpu_control === 1'b1) ctrl_cnt++;
      chk({tag, "_control"}, 96'(tpu_control), 96'(c < 4 + LS));
      chk({tag, "_wt"}, 96'(tpu_wt_arr), 96'(exp_wt));
      chk({tag, "_data"}, 96'(tpu_data_arr), 96'(exp_data));
      chk({tag, "_run_res_valid"}, 96'(res_valid), 96'd0);
      chk({tag, "_run_in_ready"}, 96'(in_ready), 96'd0);
      chk({tag, "_run_busy"}, 96'(busy), 96'd1);
      if (j.start_extra && c == 1) start = 1'b1;
      if (t == j.abort_t) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check_quiet({tag, "_abort"});
        return;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, "_ctrl_cycles"}, 96'(ctrl_cnt), 96'(j.exp_ctrl_cycles));
    k = 0;
    guard = 0;
    bp_left = j.bp_len;
    while (k < 4 && guard < 40) begin
      chk({tag, "_res_valid"}, 96'(res_valid), 96'd1);
      chk({tag, "_res_data"}, res_data, pe_t[OD + k]);
      chk({tag, "_out_done"}, 96'(done), 96'd0);
      if (k == j.bp_k && bp_left > 0) begin
        res_ready = 1'b0;
        bp_left--;
      end else begin
        res_ready = 1'b1;
      end
      start = (k == 3 && res_ready && j.start_extra);
      pe_bus = rand96();
      tick();
      start = 1'b0;
      if (res_ready) k++;
      guard++;
    end
    if (k < 4) chk({tag, "_output_timeout"}, 96'(k), 96'd4);
    res_ready = 1'b0;
    chk({tag, "_done_pulse"}, 96'(done), 96'd1);
    chk({tag, "_done_busy"}, 96'(busy), 96'd0);
    chk({tag, "_done_res_valid"}, 96'(res_valid), 96'd0);
    tick();
    check_quiet({tag, "_after"});
    tick();
    chk({tag, "_still_idle"}, 96'(busy), 96'd0);
  endtask

  initial begin
    logic [7:0][31:0] idb, rb;
    job_t rj;
    idb = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
           32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    // beats, gap_at, gap_len, bp_k, bp_len, start_extra, abort_t
    jobs[0] = mk(idb, 8, 0, 4, 0, 1'b0, -1);
    jobs[1] = mk(idb, 6, 3, 4, 0, 1'b0, -1);
    jobs[2] = mk(idb, 8, 0, 1, 5, 1'b0, -1);
    jobs[3] = mk(idb, 8, 0, 4, 0, 1'b0, 2);
    jobs[4] = mk(idb, 2, 1, 3, 2, 1'b1, -1);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    res_ready = 1'b0; pe_bus = 96'd0;
    tick();
    check_quiet("in_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_quiet("post_reset");

    for (int n = 0; n < 5; n++) begin
      run_job(jobs[n], $sformatf("job%0d", n));
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) rb[i] = $urandom();
      rj = mk(rb, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), -1);
      run_job(rj, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
